// File: rtl/keypad_scanner_if.sv
// CPU-side register bus of the keypad scanner: load/store strobes, word address,
// write data and combinational read data.
interface keypad_scanner_if #(
    parameter int XLEN         = 32,
    parameter int KEY_ADDR_LEN = 2
);
    logic                    re;
    logic                    we;
    logic [KEY_ADDR_LEN-1:0] addr;
    logic [XLEN-1:0]         wdata;
    logic [XLEN-1:0]         rdata;

    modport master (output re, we, addr, wdata, input rdata);
    modport slave  (input re, we, addr, wdata, output rdata);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, full-matrix debounce, key-press
// event FIFO with overflow flag, memory-mapped to the CPU and irq while non-empty.
module keypad_scanner #(
    parameter int XLEN            = 32,
    parameter int KEY_ADDR_LEN    = 2,
    parameter int SCAN_DIV_WIDTH  = 10,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.slave   bus,
    input  logic [3:0]        row_n,
    output logic [3:0]        col_n,
    output logic              irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int DB_W  = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

    localparam logic [DB_W-1:0]         DB_MAX   = DB_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [KEY_ADDR_LEN-1:0] A_STATUS = KEY_ADDR_LEN'(0);
    localparam logic [KEY_ADDR_LEN-1:0] A_DATA   = KEY_ADDR_LEN'(1);
    localparam logic [KEY_ADDR_LEN-1:0] A_STATE  = KEY_ADDR_LEN'(2);
    localparam logic [KEY_ADDR_LEN-1:0] A_CTRL   = KEY_ADDR_LEN'(3);

    // State
    logic [3:0]                row_meta_q, row_meta_d;
    logic [3:0]                row_sync_q, row_sync_d;
    logic [SCAN_DIV_WIDTH-1:0] divider_q, divider_d;
    logic [1:0]                col_sel_q, col_sel_d;
    logic [3:0]                col_n_q, col_n_d;
    logic [15:0]               frame_q, frame_d;
    logic [15:0]               candidate_q, candidate_d;
    logic [DB_W-1:0]           stable_cnt_q, stable_cnt_d;
    logic [15:0]               debounced_q, debounced_d;
    logic [15:0]               pending_q, pending_d;
    logic [3:0]                mem_q [FIFO_DEPTH];
    logic [3:0]                mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      ovf_q, ovf_d;

    // Combinational helpers
    logic        tick;
    logic        frame_end;
    logic [3:0]  row;
    logic        accept;
    logic [15:0] new_ev;
    logic        ev_valid;
    logic [3:0]  ev_code;
    logic [15:0] ev_clr;
    logic        not_empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        ovf_set;
    logic        ctrl_wr;
    logic        flush;
    logic [XLEN-1:0] rdata;
    logic        unused_wdata;

    assign unused_wdata = ^bus.wdata[XLEN-1:2];

    // Scan: 2-FF synchronizer, tick divider and column strobe
    always_comb begin
        row_meta_d = row_n;
        row_sync_d = row_meta_q;
        row        = ~row_sync_q;
        divider_d  = divider_q + 1'b1;
        tick       = &divider_q;
        col_sel_d  = col_sel_q;
        col_n_d    = col_n_q;
        frame_d    = frame_q;
        frame_end  = 1'b0;
        if (tick) begin
            frame_d[{col_sel_q, 2'b00} +: 4] = row;
            col_sel_d = col_sel_q + 2'd1;
            col_n_d   = ~(4'b0001 << col_sel_d);
            frame_end = (col_sel_q == 2'd3);
        end
    end

    // Debounce: frame_d at frame end is the full matrix including the last column
    always_comb begin
        candidate_d  = candidate_q;
        stable_cnt_d = stable_cnt_q;
        debounced_d  = debounced_q;
        accept       = 1'b0;
        if (frame_end) begin
            if (frame_d == candidate_q) begin
                if (stable_cnt_q != DB_MAX)
                    stable_cnt_d = stable_cnt_q + 1'b1;
                if (stable_cnt_q == DB_MAX && frame_d != debounced_q) begin
                    debounced_d = frame_d;
                    accept      = 1'b1;
                end
            end else begin
                candidate_d  = frame_d;
                stable_cnt_d = '0;
            end
        end
        // Only newly pressed keys become events; releases are silent
        new_ev = accept ? (frame_d & ~debounced_q) : 16'h0000;
    end

    // Event drain: lowest pending key code first, one per cycle
    always_comb begin
        ev_valid = |pending_q;
        ev_code  = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (pending_q[i]) ev_code = 4'(i);
        ev_clr = 16'h0000;
        if (ev_valid) ev_clr[ev_code] = 1'b1;
        pending_d = (pending_q & ~ev_clr) | new_ev;
    end

    // Event FIFO and control register
    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == CNT_FULL);
        pop       = bus.re && (bus.addr == A_DATA) && not_empty;
        push      = ev_valid && (!full || pop);
        ovf_set   = ev_valid && !push;
        ctrl_wr   = bus.we && (bus.addr == A_CTRL);
        flush     = ctrl_wr && bus.wdata[1];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = ev_code;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        ovf_d = ovf_q;
        if (ctrl_wr && bus.wdata[0]) ovf_d = 1'b0;
        // A drop in the same cycle wins over the clear
        if (ovf_set) ovf_d = 1'b1;
    end

    // Register read mux
    always_comb begin
        rdata = '0;
        case (bus.addr)
            A_STATUS: begin
                rdata[0]    = not_empty;
                rdata[1]    = ovf_q;
                rdata[15:8] = 8'(count_q);
            end
            A_DATA: begin
                if (not_empty) begin
                    rdata[3:0] = mem_q[rd_ptr_q];
                    rdata[8]   = 1'b1;
                end
            end
            A_STATE: rdata[15:0] = debounced_q;
            default: rdata = '0;
        endcase
    end

    assign bus.rdata = rdata;
    assign col_n     = col_n_q;
    assign irq       = not_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q   <= 4'hF;
            row_sync_q   <= 4'hF;
            divider_q    <= '0;
            col_sel_q    <= 2'd0;
            col_n_q      <= 4'b1110;
            frame_q      <= '0;
            candidate_q  <= '0;
            stable_cnt_q <= '0;
            debounced_q  <= '0;
            pending_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            row_meta_q   <= row_meta_d;
            row_sync_q   <= row_sync_d;
            divider_q    <= divider_d;
            col_sel_q    <= col_sel_d;
            col_n_q      <= col_n_d;
            frame_q      <= frame_d;
            candidate_q  <= candidate_d;
            stable_cnt_q <= stable_cnt_d;
            debounced_q  <= debounced_d;
            pending_q    <= pending_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end
endmodule
